// File: rtl/alu32_pkg.sv
// ---------------------------------------------------------------------------
// alu32_pkg
// Shared definitions for the alu32 sequencer and anything that drives or
// observes the alu32 select lines.
//   OP_ADD .. OP_NOR : 3-bit operation codes understood by alu32
//   state_t          : sequencer state encoding
// ---------------------------------------------------------------------------
package alu32_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MULT = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;
   localparam logic [2:0] OP_NOR  = 3'b111;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      EXEC  = 3'd1,
      MRST  = 3'd2,
      MWAIT = 3'd3,
      CAPT  = 3'd4
   } state_t;

endpackage

// File: rtl/alu32_sequencer.sv
// ---------------------------------------------------------------------------
// alu32_sequencer
// Accepts one operation at a time, holds its operands/opcode steady on the
// alu32 inputs, gives the sequential multiplier a reset pulse plus the
// cycles it needs, then captures the ALU result.
//
// Parameters
//   MULT_CYCLES : cycles the multiplier needs after its reset is released
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   request one operation (only looked at in IDLE)
//   op_in      in   [2:0]  operation code
//   a_in, b_in in   [31:0] operands
//   alu_a/b    out  [31:0] operands held for the ALU
//   alu_op     out  [2:0]  opcode held for the ALU
//   alu_reset  out  reset to the ALU multiplier
//   alu_result in   [63:0] ALU result
//   busy       out  operation in flight
//   done       out  one-cycle pulse when result_out updates
//   result_out out  [63:0] result of the last completed operation
// ---------------------------------------------------------------------------
module alu32_sequencer
   import alu32_pkg::*;
#(
   parameter int MULT_CYCLES = 32
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op_in,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_op,
   output logic        alu_reset,
   input  logic [63:0] alu_result,
   output logic        busy,
   output logic        done,
   output logic [63:0] result_out
);

   // One extra bit over $clog2 so MULT_CYCLES-1 always fits, including
   // MULT_CYCLES=1 where the counter is loaded with zero.
   localparam int CW = $clog2(MULT_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MULT_CYCLES - 1);

   state_t state;
   state_t state_next;
   logic [CW-1:0] count;
   logic take_start;
   logic load_count;
   logic dec_count;
   logic capture;

   // State register. Reset always lands in IDLE, which also abandons any
   // operation in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control decode. start is only honoured in IDLE, so a
   // request during an operation (including CAPT) is simply dropped. MWAIT
   // stops counting at zero and leaves for CAPT on the following edge.
   // alu_reset follows the system reset so the multiplier is also held
   // while the sequencer is.
   always_comb begin
      state_next = state;
      take_start = 1'b0;
      load_count = 1'b0;
      dec_count  = 1'b0;
      capture    = 1'b0;
      alu_reset  = reset;
      case (state)
         IDLE: begin
            if (start) begin
               take_start = 1'b1;
               state_next = (op_in == OP_MULT) ? MRST : EXEC;
            end
         end
         EXEC: begin
            state_next = CAPT;
         end
         MRST: begin
            alu_reset  = 1'b1;
            load_count = 1'b1;
            state_next = MWAIT;
         end
         MWAIT: begin
            if (count == '0) begin
               state_next = CAPT;
            end else begin
               dec_count = 1'b1;
            end
         end
         CAPT: begin
            capture    = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath registers. Operands are latched only on acceptance so later
   // input changes cannot disturb the ALU. Non-multiply results only carry
   // a 32-bit value, so the upper word is forced to zero whatever the ALU
   // drives there.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= OP_ADD;
         busy       <= 1'b0;
         done       <= 1'b0;
         result_out <= '0;
         count      <= '0;
      end else begin
         done <= capture;
         if (take_start) begin
            alu_a  <= a_in;
            alu_b  <= b_in;
            alu_op <= op_in;
            busy   <= 1'b1;
         end
         if (capture) begin
            busy <= 1'b0;
            if (alu_op == OP_MULT) begin
               result_out <= alu_result;
            end else begin
               result_out <= {32'd0, alu_result[31:0]};
            end
         end
         if (load_count) begin
            count <= CNT_LOAD;
         end else if (dec_count) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu32_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu32_sequencer
// Bench for alu32_sequencer. A small behavioural alu32 stand-in sits on the
// ALU ports; its multiplier only gives a valid product once it has had
// MC clocks out of reset. Stimulus pushes hand-computed results and done
// cycles into a queue; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_alu32_sequencer;
   import alu32_pkg::*;

   localparam int MC = 6;

   typedef struct {
      logic [63:0] result;
      int          done_cyc;
   } sb_entry_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op_in;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_op;
   logic        alu_reset;
   logic [63:0] alu_result;
   logic        busy;
   logic        done;
   logic [63:0] result_out;

   sb_entry_t exp_q[$];
   int cyc = 0;
   int mult_age = 0;
   int areset_pulses = 0;
   int n_checks = 0;
   int n_fail = 0;

   alu32_sequencer #(.MULT_CYCLES(MC)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .op_in(op_in),
      .a_in(a_in),
      .b_in(b_in),
      .alu_a(alu_a),
      .alu_b(alu_b),
      .alu_op(alu_op),
      .alu_reset(alu_reset),
      .alu_result(alu_result),
      .busy(busy),
      .done(done),
      .result_out(result_out)
   );

   // Free-running clock and an edge counter used to timestamp done pulses.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Multiplier readiness: counts clocks since alu_reset was last seen high.
   always @(posedge clk) begin
      if (alu_reset) mult_age <= 0;
      else if (mult_age < 1000) mult_age <= mult_age + 1;
   end

   // alu32 stand-in. The upper word is junk on non-multiply ops and the
   // product is poisoned until the multiplier has had its MC cycles.
   logic [31:0] alu_lo;
   logic [63:0] product;
   always_comb begin
      product = {32'd0, alu_a} * {32'd0, alu_b};
      alu_lo  = '0;
      case (alu_op)
         OP_ADD: alu_lo = alu_a + alu_b;
         OP_SUB: alu_lo = alu_a - alu_b;
         OP_XOR: alu_lo = alu_a ^ alu_b;
         OP_AND: alu_lo = alu_a & alu_b;
         OP_OR:  alu_lo = alu_a | alu_b;
         OP_SLT: alu_lo = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         OP_NOR: alu_lo = ~(alu_a | alu_b);
         default: alu_lo = '0;
      endcase
      if (alu_op == OP_MULT) alu_result = (mult_age >= MC) ? product : 64'hBAD0_BAD0_BAD0_BAD0;
      else alu_result = {32'hDEAD_BEEF, alu_lo};
   end

   // Count cycles with the multiplier reset asserted outside system reset.
   always @(negedge clk) begin
      if (!reset && alu_reset) areset_pulses <= areset_pulses + 1;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation,
   // both in value and in the clock edge it arrived on.
   always @(negedge clk) begin
      sb_entry_t e;
      if (done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
         end else begin
            e = exp_q.pop_front();
            checkOutput("result", result_out, e.result);
            checkOutput("latency", 64'(cyc), 64'(e.done_cyc));
         end
      end
   end

   task automatic waitIdle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL idle_timeout: got busy=1 after %0d cycles, expected 0", n);
      end
   endtask

   // Issue one start at a negedge while idle; acceptance happens on the
   // next rising edge, so done is due latency edges after that.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] expected, input int latency, input bit expect_done);
      sb_entry_t e;
      waitIdle();
      op_in = op;
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      if (expect_done) begin
         e.result   = expected;
         e.done_cyc = cyc + 1 + latency;
         exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   logic [31:0] xor_exp [4] = '{32'h0000_10FF, 32'h0000_10FC, 32'h0000_10F9, 32'h0000_10F6};
   int pulses_before;

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op_in = OP_ADD;
      a_in  = '0;
      b_in  = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_result", result_out, 64'd0);
      checkOutput("rst_alu_a", 64'(alu_a), 64'd0);
      checkOutput("rst_alu_op", 64'(alu_op), 64'd0);
      checkOutput("rst_alu_reset", 64'(alu_reset), 64'd1);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle_alu_reset", 64'(alu_reset), 64'd0);

      // Add 5+7.
      applyStimulus(OP_ADD, 32'd5, 32'd7, 64'd12, 2, 1'b1);
      waitIdle();
      checkOutput("add_busy_after", 64'(busy), 64'd0);

      // Multiply with a start request arriving mid-operation.
      pulses_before = areset_pulses;
      applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, MC + 2, 1'b1);
      repeat (2) @(negedge clk);
      start = 1'b1;
      op_in = OP_ADD;
      a_in  = 32'd1;
      b_in  = 32'd1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      waitIdle();
      checkOutput("mult_alu_reset_cycles", 64'(areset_pulses - pulses_before), 64'd1);
      repeat (6) @(negedge clk);
      checkOutput("mult_result_kept", result_out, 64'h0000_0001_FFFF_FFFE);

      // Signed compare, subtract, carry-out discard and logic ops.
      applyStimulus(OP_SLT, 32'hFFFF_FFFF, 32'd1, 64'd1, 2, 1'b1);
      applyStimulus(OP_SLT, 32'd1, 32'hFFFF_FFFF, 64'd0, 2, 1'b1);
      applyStimulus(OP_SUB, 32'd3, 32'd5, 64'h0000_0000_FFFF_FFFE, 2, 1'b1);
      applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'd1, 64'd0, 2, 1'b1);
      applyStimulus(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 64'h0000_0000_00F0_1200, 2, 1'b1);
      applyStimulus(OP_OR,  32'hF000_0001, 32'h0000_00F0, 64'h0000_0000_F000_00F1, 2, 1'b1);
      applyStimulus(OP_NOR, 32'h0000_0000, 32'hFFFF_0000, 64'h0000_0000_0000_FFFF, 2, 1'b1);

      // Abort a multiply in MWAIT; no done may follow.
      applyStimulus(OP_MULT, 32'd9, 32'd9, 64'd81, MC + 2, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_result", result_out, 64'd0);
      checkOutput("abort_alu_reset", 64'(alu_reset), 64'd1);
      reset = 1'b0;
      repeat (MC + 4) @(negedge clk);
      checkOutput("abort_result_later", result_out, 64'd0);
      applyStimulus(OP_ADD, 32'd1, 32'd1, 64'd2, 2, 1'b1);
      waitIdle();

      // start held for 10 cycles with operands changing every cycle:
      // accepts land every third edge, never during CAPT.
      for (int i = 0; i < 10; i++) begin
         start = 1'b1;
         op_in = OP_XOR;
         a_in  = 32'h0000_1000 + 32'(i);
         b_in  = 32'h0000_00FF;
         if (i % 3 == 0) exp_q.push_back('{result: {32'd0, xor_exp[i / 3]}, done_cyc: cyc + 3});
         @(negedge clk);
      end
      start = 1'b0;
      waitIdle();
      repeat (6) @(negedge clk);
      checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu32_sequencer.md
ALU32_SEQUENCER -- requirements
Module: alu32_sequencer

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 32: clock cycles the sequential multiplier needs after its reset is released.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to execute one operation; sampled only in IDLE.
REQ-005 SHALL have port op_in  input  3  operation code: 000 add, 001 sub, 010 mult, 011 xor, 100 and, 101 or, 110 slt, 111 nor.
REQ-006 SHALL have ports a_in and b_in  input  32 each  operands.
REQ-007 SHALL have port alu_a, alu_b  output  32 each  registered operands driven to the ALU.
REQ-008 SHALL have port alu_op  output  3  registered opcode driven to the ALU select.
REQ-009 SHALL have port alu_reset  output  1  reset to the ALU multiplier.
REQ-010 SHALL have port alu_result  input  64  ALU result.
REQ-011 SHALL have port busy  output  1  high from start acceptance until done.
REQ-012 SHALL have port done  output  1  one-cycle pulse when result_out is updated.
REQ-013 SHALL have port result_out  output  64  registered result of the last completed operation.

Function
REQ-014 SHALL implement states IDLE, EXEC, MRST, MWAIT, CAPT.
REQ-015 In IDLE with start=1, SHALL latch a_in/b_in/op_in into alu_a/alu_b/alu_op, set busy, and go to MRST if op_in=010, else EXEC.
REQ-016 EXEC SHALL last exactly one cycle for settling, then go to CAPT.
REQ-017 MRST SHALL assert alu_reset for exactly one cycle, load a down-counter with MULT_CYCLES-1, then go to MWAIT.
REQ-018 MWAIT SHALL decrement the counter each cycle and go to CAPT in the cycle after the counter reads 0; alu_reset SHALL be 0 there.
REQ-019 CAPT SHALL register alu_result into result_out, pulse done for one cycle, clear busy, and return to IDLE.
REQ-020 Latency from start-accept edge to done: 2 cycles for non-multiply ops; MULT_CYCLES+2 for multiply.
REQ-021 For non-multiply ops, result_out[63:32] SHALL equal 0.
REQ-022 start while busy=1 SHALL be ignored, with no queuing; start in the CAPT cycle SHALL be ignored.
REQ-023 a_in/b_in/op_in changes while busy SHALL NOT affect alu_a/alu_b/alu_op.
REQ-024 start asserted on consecutive cycles SHALL launch back-to-back operations, with accept on the first IDLE cycle after done.
REQ-025 The counter width SHALL be $clog2(MULT_CYCLES)+1 bits; MULT_CYCLES=1 SHALL give zero MWAIT decrements beyond the load, i.e. latency 3.

Reset
REQ-026 reset SHALL force IDLE, with busy=0, done=0, result_out=0, alu_a=0, alu_b=0, alu_op=000, counter=0.
REQ-027 alu_reset SHALL be 1 while reset=1.
REQ-028 reset asserted mid-operation (any state) SHALL abort without a done pulse; result_out SHALL be 0 after reset.

Structure
REQ-029 The opcode constants (OP_ADD..OP_NOR) and the state encoding SHALL live in a shared package alu32_pkg.
REQ-030 The sequencer SHALL be a single module with no sub-modules.
REQ-031 The team's existing alu32 SHALL be instantiated only in the testbench/top, with alu_reset tied to its reset.

Verification
REQ-032 Add: reset, then start with op=000, a=5, b=7 -> done 2 cycles after accept, result_out=64'd12, busy low after.
REQ-033 Mult: op=010, a=32'hFFFF_FFFF, b=2 -> alu_reset pulse 1 cycle, done at cycle MULT_CYCLES+2, result_out=64'h1_FFFF_FFFE.
REQ-034 Ignored start: start again mid-multiply with op=000 -> no extra done; result_out equals the multiply result.
REQ-035 Slt: op=110, a=32'hFFFF_FFFF (-1), b=1 -> result_out=64'd1; sub a=3, b=5 -> result_out[31:0]=32'hFFFF_FFFE, upper word 0.
REQ-036 Abort: reset during MWAIT -> no done, busy=0, result_out=0; following add 1+1 -> 64'd2.
REQ-037 Back-to-back: start held high for 10 cycles with op=011 -> done every 3 cycles, with no start accepted in CAPT.
